alu_arbiter: RTL and testbench

- Shares the single registered `alu` between two requesters.
- Each requester submits an operation (operands, zero/negate controls, opcode) over a valid/ready handshake.
- The arbiter grants one request at a time and sequences the ALU through its registered cycle.
- It captures result and flags and returns them on a per-port response handshake; it sits between the instruction-side and memory-side datapaths and the ALU.

---
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port request/response arbiter sharing one registered ALU (IDLE/ISSUE/CAPTURE/RESPOND).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module alu_arbiter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [2*DATA_WIDTH-1:0]   req_x,
    input  logic [2*DATA_WIDTH-1:0]   req_y,
    input  logic [1:0]                req_zero_x,
    input  logic [1:0]                req_zero_y,
    input  logic [1:0]                req_negate,
    input  logic [3:0]                req_opcode,
    output logic [1:0]                rsp_valid,
    input  logic [1:0]                rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      rsp_is_zero,
    output logic                      rsp_is_negative,
    output logic [DATA_WIDTH-1:0]     alu_x,
    output logic [DATA_WIDTH-1:0]     alu_y,
    output logic                      alu_zero_x,
    output logic                      alu_zero_y,
    output logic                      alu_negate_output,
    output logic [1:0]                alu_opcode,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic                      alu_is_zero,
    input  logic                      alu_is_negative
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;

    state_t                state_reg, state_next;
    logic                  grant;
    logic                  accept;
    logic                  port_reg;
    logic [DATA_WIDTH-1:0] x_reg, y_reg;
    logic                  zero_x_reg, zero_y_reg, negate_reg;
    logic [1:0]            opcode_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;
    logic                  rsp_is_zero_reg, rsp_is_negative_reg;

    logic [DATA_WIDTH-1:0] port_x      [2];
    logic [DATA_WIDTH-1:0] port_y      [2];
    logic [1:0]            port_opcode [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign port_x[gi]      = req_x[gi*DATA_WIDTH +: DATA_WIDTH];
        assign port_y[gi]      = req_y[gi*DATA_WIDTH +: DATA_WIDTH];
        assign port_opcode[gi] = req_opcode[2*gi +: 2];
    end

    assign accept = (state_reg == IDLE) && (|req_valid);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant = ~req_valid[0];
`else
    // last_reg resets to 1 so port 0 wins the first contention.
    logic last_reg;

    assign grant = (req_valid == 2'b11) ? ~last_reg : req_valid[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (accept) begin
            last_reg <= grant;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = RESPOND;
            RESPOND: if (rsp_ready[port_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (accept) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
        if (state_reg == RESPOND) begin
            rsp_valid = port_reg ? 2'b10 : 2'b01;
        end
    end

    // The op register stays put after completion so the ALU inputs remain stable
    // through CAPTURE, where the ALU's negate/flags are still combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_reg   <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            zero_x_reg <= 1'b0;
            zero_y_reg <= 1'b0;
            negate_reg <= 1'b0;
            opcode_reg <= 2'b00;
        end else if (accept) begin
            port_reg   <= grant;
            x_reg      <= port_x[grant];
            y_reg      <= port_y[grant];
            zero_x_reg <= req_zero_x[grant];
            zero_y_reg <= req_zero_y[grant];
            negate_reg <= req_negate[grant];
            opcode_reg <= port_opcode[grant];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_reg        <= '0;
            rsp_is_zero_reg     <= 1'b0;
            rsp_is_negative_reg <= 1'b0;
        end else if (state_reg == CAPTURE) begin
            rsp_data_reg        <= alu_result;
            rsp_is_zero_reg     <= alu_is_zero;
            rsp_is_negative_reg <= alu_is_negative;
        end
    end

    assign alu_x             = x_reg;
    assign alu_y             = y_reg;
    assign alu_zero_x        = zero_x_reg;
    assign alu_zero_y        = zero_y_reg;
    assign alu_negate_output = negate_reg;
    assign alu_opcode        = opcode_reg;

    assign rsp_data        = rsp_data_reg;
    assign rsp_is_zero     = rsp_is_zero_reg;
    assign rsp_is_negative = rsp_is_negative_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural registered ALU and a reference model.
// Honours ALU_ARB_FIXED_PRIO_EN when choosing arbitration expectations.
module tb_alu_arbiter;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2*DW-1:0] req_x, req_y;
    logic [1:0]      req_zero_x, req_zero_y, req_negate;
    logic [3:0]      req_opcode;
    logic [DW-1:0]   rsp_data, alu_x, alu_y, alu_result;
    logic            rsp_is_zero, rsp_is_negative;
    logic            alu_zero_x, alu_zero_y, alu_negate_output;
    logic [1:0]      alu_opcode;
    logic            alu_is_zero, alu_is_negative;

    logic [DW-1:0]   op_x [2];
    logic [DW-1:0]   op_y [2];
    logic            op_zx [2];
    logic            op_zy [2];
    logic            op_neg [2];
    logic [1:0]      op_opc [2];

    int   n_assert = 0;
    int   n_fail   = 0;
    logic model_last;

    always #5 clk = ~clk;

    assign req_x      = {op_x[1], op_x[0]};
    assign req_y      = {op_y[1], op_y[0]};
    assign req_zero_x = {op_zx[1], op_zx[0]};
    assign req_zero_y = {op_zy[1], op_zy[0]};
    assign req_negate = {op_neg[1], op_neg[0]};
    assign req_opcode = {op_opc[1], op_opc[0]};

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .req_zero_x(req_zero_x), .req_zero_y(req_zero_y), .req_negate(req_negate),
        .req_opcode(req_opcode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_is_zero(rsp_is_zero), .rsp_is_negative(rsp_is_negative),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zero_x(alu_zero_x), .alu_zero_y(alu_zero_y), .alu_negate_output(alu_negate_output),
        .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_is_zero(alu_is_zero), .alu_is_negative(alu_is_negative)
    );

    // Stand-in ALU: registered pre-negation value, combinational negate and flags.
    logic [DW-1:0] alu_pre;
    logic [DW-1:0] alu_a, alu_b;
    assign alu_a = alu_zero_x ? '0 : alu_x;
    assign alu_b = alu_zero_y ? '0 : alu_y;
    always @(posedge clk) begin
        case (alu_opcode)
            2'd0:    alu_pre <= alu_a | alu_b;
            2'd1:    alu_pre <= alu_a & alu_b;
            2'd2:    alu_pre <= alu_a + alu_b;
            default: alu_pre <= alu_a - alu_b;
        endcase
    end
    assign alu_result      = alu_negate_output ? ~alu_pre : alu_pre;
    assign alu_is_zero     = (alu_pre == '0);
    assign alu_is_negative = alu_result[DW-1];

    // Expected {is_zero, is_negative, data} for the op held for port p.
    function automatic logic [DW+1:0] ref_op(input int p);
        int unsigned a, b, r;
        logic [DW-1:0] pre, res;
        a = op_zx[p] ? 0 : int'(op_x[p]);
        b = op_zy[p] ? 0 : int'(op_y[p]);
        case (op_opc[p])
            2'd0:    r = a | b;
            2'd1:    r = a & b;
            2'd2:    r = a + b;
            default: r = a + 32'h10000 - b;
        endcase
        pre = r[DW-1:0];
        res = op_neg[p] ? (16'hFFFF ^ pre) : pre;
        return {pre == 0, res >= 16'h8000, res};
    endfunction

    function automatic int pick(input logic [1:0] pend);
        if (pend == 2'b01) return 0;
        if (pend == 2'b10) return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 0;
`else
        return model_last ? 0 : 1;
`endif
    endfunction

    function automatic logic [1:0] onehot(input int g);
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic note_accept(input int g);
`ifndef ALU_ARB_FIXED_PRIO_EN
        model_last = (g == 1);
`endif
    endtask

    task automatic set_op(input int p, input logic [DW-1:0] x, input logic [DW-1:0] y,
                          input logic zx, input logic zy, input logic neg, input logic [1:0] opc);
        op_x[p] = x; op_y[p] = y; op_zx[p] = zx; op_zy[p] = zy; op_neg[p] = neg; op_opc[p] = opc;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; model_last = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Present the ports in mask (called at negedge) and run every op to completion.
    task automatic serve(input logic [1:0] mask);
        logic [1:0]    pend;
        logic [DW+1:0] exp;
        int g, waitc;
        pend = mask;
        req_valid = mask;
        #1;
        while (pend != 2'b00) begin
            g = pick(pend);
            waitc = 0;
            while (req_ready == 2'b00 && waitc < 16) begin
                @(negedge clk); #1; waitc++;
            end
            check(req_ready, onehot(g), "grant");
            if (req_ready != onehot(g)) begin
                reset_dut();
                return;
            end
            note_accept(g);
            exp = ref_op(g);
            @(negedge clk);
            req_valid[g] = 1'b0; pend[g] = 1'b0;
            #1;
            check(rsp_valid, 0, "issue_rsp_valid");
            check(alu_x, op_x[g], "issue_alu_x");
            check(alu_opcode, op_opc[g], "issue_alu_opcode");
            @(negedge clk); #1;
            check(rsp_valid, 0, "capture_rsp_valid");
            check(req_ready, 0, "busy_req_ready");
            @(negedge clk); #1;
            check(rsp_valid, onehot(g), "rsp_valid");
            check(rsp_data, exp[DW-1:0], "rsp_data");
            check(rsp_is_zero, exp[DW+1], "rsp_is_zero");
            check(rsp_is_negative, exp[DW], "rsp_is_negative");
            $display("op port%0d opc=%0d x=%h y=%h zx=%0d zy=%0d neg=%0d -> data=%h z=%0d n=%0d",
                     g, op_opc[g], op_x[g], op_y[g], op_zx[g], op_zy[g], op_neg[g],
                     rsp_data, rsp_is_zero, rsp_is_negative);
            rsp_ready[g] = 1'b1;
            @(negedge clk);
            rsp_ready = 2'b00;
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW+1:0] exp;
        int g, cur_g;

        set_op(0, '0, '0, 0, 0, 0, 2'd0);
        set_op(1, '0, '0, 0, 0, 0, 2'd0);
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; model_last = 1'b1;
        #1;
        check(req_ready, 0, "reset_req_ready");
        check(rsp_valid, 0, "reset_rsp_valid");
        check(rsp_data, 0, "reset_rsp_data");
        check(alu_x, 0, "reset_alu_x");
        check(alu_opcode, 0, "reset_alu_opcode");
        reset_dut();

        // Directed single ops
        set_op(0, 16'd5, 16'd7, 0, 0, 0, 2'd3);
        serve(2'b01);
        set_op(1, 16'h00F0, 16'h0F0F, 0, 0, 1, 2'd1);
        serve(2'b10);
        set_op(0, 16'h1234, 16'h00FF, 1, 0, 0, 2'd0);
        serve(2'b01);

        // Response backpressure on port 0 while port 1 waits
        set_op(0, 16'd10, 16'd20, 0, 0, 0, 2'd2);
        set_op(1, 16'd9, 16'd4, 0, 0, 0, 2'd3);
        req_valid = 2'b01;
        #1;
        check(req_ready, 2'b01, "bp_grant");
        note_accept(0);
        exp = ref_op(0);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        check(req_ready, 0, "bp_issue_ready");
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            check(rsp_valid, 2'b01, "bp_rsp_valid");
            check(rsp_data, exp[DW-1:0], "bp_rsp_data");
            check(req_ready, 0, "bp_req_ready");
            if (k < 5) begin
                @(negedge clk); #1;
            end
        end
        $display("backpressure port0 held data=%h", rsp_data);
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        check(req_ready, 2'b10, "bp_release_accept");
        serve(2'b10);

        // Continuous contention with responses always accepted
        reset_dut();
        set_op(0, 16'd1, 16'd2, 0, 0, 0, 2'd2);
        set_op(1, 16'd3, 16'd4, 0, 0, 0, 2'd2);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        cur_g = 0;
        #1;
        for (int c = 0; c < 16; c++) begin
            if (c % 4 == 0) begin
                g = pick(2'b11);
                check(req_ready, onehot(g), "contend_grant");
                note_accept(g);
                cur_g = g;
            end
            if (c % 4 == 3) begin
                exp = ref_op(cur_g);
                check(rsp_valid, onehot(cur_g), "contend_rsp_valid");
                check(rsp_data, exp[DW-1:0], "contend_rsp_data");
                $display("contend grant port%0d data=%0d", cur_g, rsp_data);
            end
            @(negedge clk); #1;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk); #1;

        // Reset during CAPTURE
        set_op(0, 16'd100, 16'd23, 0, 0, 0, 2'd2);
        req_valid = 2'b01;
        #1;
        check(req_ready, 2'b01, "rst_grant");
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        model_last = 1'b1;
        #1;
        check(rsp_valid, 0, "midrst_rsp_valid");
        check(req_ready, 0, "midrst_req_ready");
        check(alu_x, 0, "midrst_alu_x");
        check(alu_y, 0, "midrst_alu_y");
        check(rsp_data, 0, "midrst_rsp_data");
        $display("reset asserted during capture");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check(rsp_valid, 0, "postrst_no_rsp");
        end
        set_op(0, 16'd40, 16'd2, 0, 0, 0, 2'd2);
        set_op(1, 16'd50, 16'd5, 0, 0, 0, 2'd3);
        serve(2'b11);

        // Randomized ops against the reference model
        for (int it = 0; it < 16; it++) begin
            for (int p = 0; p < 2; p++) begin
                set_op(p, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)));
            end
            serve(2'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
